// File: rtl/spike_count_classifier_if.sv
// Spike-count classifier bus: AER spike input, step pulses and the classification result.
// Defining SPIKE_CLASSIFIER_MARGIN_EN adds the result_margin signal.
interface spike_count_classifier_if #(
    parameter int CNT_W = 8
);
    logic             spike_in;
    logic [5:0]       spike_AER;
    logic             current_step_finished;
    logic             result_valid;
    logic [5:0]       result_class;
    logic [CNT_W-1:0] result_count;
    logic             busy;
    logic             spike_dropped;
`ifdef SPIKE_CLASSIFIER_MARGIN_EN
    logic [CNT_W-1:0] result_margin;
`endif

    // Master is the spike-generation side, slave is the classifier.
    modport master (
        output spike_in, spike_AER, current_step_finished,
        input  result_valid, result_class, result_count, busy, spike_dropped
`ifdef SPIKE_CLASSIFIER_MARGIN_EN
        , input result_margin
`endif
    );

    modport slave (
        input  spike_in, spike_AER, current_step_finished,
        output result_valid, result_class, result_count, busy, spike_dropped
`ifdef SPIKE_CLASSIFIER_MARGIN_EN
        , output result_margin
`endif
    );
endinterface

// File: rtl/spike_count_classifier.sv
// Per-neuron spike counting over NUM_STEPS timesteps, followed by an argmax scan and a result pulse.
// Optional macro SPIKE_CLASSIFIER_MARGIN_EN adds a best-minus-second-best margin output.
module spike_count_classifier #(
    parameter int NUM_NEURONS = 40,
    parameter int NUM_STEPS   = 200,
    parameter int CNT_W       = 8,
    parameter int STEP_W      = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    spike_count_classifier_if.slave  bus
);
    localparam logic [1:0] ST_ACCUM  = 2'd0;
    localparam logic [1:0] ST_SCAN   = 2'd1;
    localparam logic [1:0] ST_REPORT = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [5:0]        idx_q, idx_d;
    logic [CNT_W-1:0]  best_cnt_q, best_cnt_d;
    logic [5:0]        best_idx_q, best_idx_d;
    logic              result_valid_q, result_valid_d;
    logic [5:0]        result_class_q, result_class_d;
    logic [CNT_W-1:0]  result_count_q, result_count_d;
    logic              busy_q, busy_d;
    logic              spike_dropped_q, spike_dropped_d;
`ifdef SPIKE_CLASSIFIER_MARGIN_EN
    logic [CNT_W-1:0]  second_q, second_d;
    logic [CNT_W-1:0]  result_margin_q, result_margin_d;
`endif

    logic                   in_accum;
    logic                   spike_ok;
    logic                   clear_all;
    logic [CNT_W-1:0]       scan_val;
    logic [CNT_W-1:0]       cnt_view [NUM_NEURONS];

    assign in_accum = (state_q == ST_ACCUM);
    // Out-of-range addresses are silently ignored, unlike spikes lost while busy.
    assign spike_ok = in_accum && bus.spike_in && ({1'b0, bus.spike_AER} < 7'(NUM_NEURONS));
    assign scan_val = cnt_view[idx_q];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_NEURONS; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_q;
            logic             hit;

            assign hit          = spike_ok && (bus.spike_AER == 6'(gi));
            assign cnt_view[gi] = cnt_q;

            always_ff @(posedge clk) begin
                if (rst || clear_all) begin
                    cnt_q <= '0;
                end else if (hit && (cnt_q != {CNT_W{1'b1}})) begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    endgenerate

    always_comb begin
        state_d         = state_q;
        step_d          = step_q;
        idx_d           = idx_q;
        best_cnt_d      = best_cnt_q;
        best_idx_d      = best_idx_q;
        result_valid_d  = 1'b0;
        result_class_d  = result_class_q;
        result_count_d  = result_count_q;
        clear_all       = 1'b0;
`ifdef SPIKE_CLASSIFIER_MARGIN_EN
        second_d        = second_q;
        result_margin_d = result_margin_q;
`endif
        spike_dropped_d = spike_dropped_q ||
                          (!in_accum && (bus.spike_in || bus.current_step_finished));

        case (state_q)
            ST_ACCUM: begin
                if (bus.current_step_finished) begin
                    if (step_q == STEP_W'(NUM_STEPS - 1)) begin
                        step_d     = '0;
                        idx_d      = '0;
                        best_cnt_d = '0;
                        best_idx_d = '0;
`ifdef SPIKE_CLASSIFIER_MARGIN_EN
                        second_d   = '0;
`endif
                        state_d    = ST_SCAN;
                    end else begin
                        step_d = step_q + 1'b1;
                    end
                end
            end
            ST_SCAN: begin
                // Strict compare keeps the lowest index on ties.
                if (scan_val > best_cnt_q) begin
                    best_cnt_d = scan_val;
                    best_idx_d = idx_q;
`ifdef SPIKE_CLASSIFIER_MARGIN_EN
                    second_d   = best_cnt_q;
                end else if (scan_val > second_q) begin
                    second_d   = scan_val;
`endif
                end
                if (idx_q == 6'(NUM_NEURONS - 1)) begin
                    state_d = ST_REPORT;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_REPORT: begin
                result_valid_d  = 1'b1;
                result_class_d  = best_idx_q;
                result_count_d  = best_cnt_q;
`ifdef SPIKE_CLASSIFIER_MARGIN_EN
                result_margin_d = best_cnt_q - second_q;
`endif
                clear_all       = 1'b1;
                state_d         = ST_ACCUM;
            end
            default: begin
                state_d = ST_ACCUM;
            end
        endcase

        busy_d = (state_d != ST_ACCUM);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_ACCUM;
            step_q          <= '0;
            idx_q           <= '0;
            best_cnt_q      <= '0;
            best_idx_q      <= '0;
            result_valid_q  <= 1'b0;
            result_class_q  <= '0;
            result_count_q  <= '0;
            busy_q          <= 1'b0;
            spike_dropped_q <= 1'b0;
`ifdef SPIKE_CLASSIFIER_MARGIN_EN
            second_q        <= '0;
            result_margin_q <= '0;
`endif
        end else begin
            state_q         <= state_d;
            step_q          <= step_d;
            idx_q           <= idx_d;
            best_cnt_q      <= best_cnt_d;
            best_idx_q      <= best_idx_d;
            result_valid_q  <= result_valid_d;
            result_class_q  <= result_class_d;
            result_count_q  <= result_count_d;
            busy_q          <= busy_d;
            spike_dropped_q <= spike_dropped_d;
`ifdef SPIKE_CLASSIFIER_MARGIN_EN
            second_q        <= second_d;
            result_margin_q <= result_margin_d;
`endif
        end
    end

    assign bus.result_valid  = result_valid_q;
    assign bus.result_class  = result_class_q;
    assign bus.result_count  = result_count_q;
    assign bus.busy          = busy_q;
    assign bus.spike_dropped = spike_dropped_q;
`ifdef SPIKE_CLASSIFIER_MARGIN_EN
    assign bus.result_margin = result_margin_q;
`endif
endmodule

// File: doc/spike_count_classifier.md
Name: spike_count_classifier

Overview:
- Downstream consumer of the spike-generation stage.
- Counts output spikes per neuron, addressed by the 6-bit AER, across a fixed number of timesteps.
- Once the final timestep completes, scans all counters to find the winning neuron (argmax), reports the winner and its count with a one-cycle valid pulse, then clears itself for the next sample.
- Its result feeds the ensemble voting logic.

Parameters:
- NUM_NEURONS, 40, number of output neurons/addresses; must be ≤ 64.
- NUM_STEPS, 200, timesteps per classification sample.
- CNT_W, 8, width of each per-neuron spike counter (saturating).
- STEP_W, 8, width of the timestep counter; requires 2^STEP_W ≥ NUM_STEPS.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- spike_in  input  1  spike valid, driven by the spike_out of the generation stage.
- spike_AER  input  6  address of the spiking neuron; only meaningful while spike_in=1.
- current_step_finished  input  1  one-cycle pulse at the end of each timestep.
- result_valid  output  1  one-cycle pulse when the result is ready.
- result_class  output  6  index of the winning neuron; held until the next report.
- result_count  output  CNT_W  spike count of the winner; held until the next report.
- busy  output  1  high while in SCAN or REPORT; spikes arriving then are dropped.
- spike_dropped  output  1  sticky flag; cleared only by rst.

Behaviour:
- Reset (rst=1 sampled at a clock edge):
  - state=ACCUM; all counters, step_cnt, scan index and best registers = 0.
  - result_valid=0, result_class=0, result_count=0, busy=0, spike_dropped=0.
  - A reset mid-SCAN or mid-REPORT aborts the operation; no result_valid is issued.
- ACCUM:
  - spike_in=1 with spike_AER < NUM_NEURONS: cnt[spike_AER] increments by 1, saturating at 2^CNT_W-1.
  - spike_in=1 with spike_AER ≥ NUM_NEURONS: ignored; no counter change, no flag.
  - current_step_finished=1 with step_cnt < NUM_STEPS-1: step_cnt increments.
  - current_step_finished=1 with step_cnt = NUM_STEPS-1: step_cnt←0, idx←0, best_cnt←0, best_idx←0, go to SCAN.
  - A spike and current_step_finished in the same cycle: the spike counts toward the current sample, including on the final step.
- SCAN (exactly NUM_NEURONS cycles, idx = 0..NUM_NEURONS-1):
  - Each cycle: if cnt[idx] > best_cnt (strict), then best_cnt←cnt[idx] and best_idx←idx.
  - Ties resolve to the lowest index; an all-zero sample gives class 0, count 0.
  - After idx = NUM_NEURONS-1, go to REPORT.
- REPORT (1 cycle):
  - result_valid=1; result_class/result_count are updated on the same edge that raises result_valid.
  - All counters clear; return to ACCUM.
- Latency: result_valid rises NUM_NEURONS+1 clock edges after the edge that samples the final current_step_finished (41 with defaults).
- busy=1 during SCAN and REPORT:
  - spike_in=1 during busy: spike discarded, spike_dropped←1.
  - current_step_finished=1 during busy: ignored (step not counted) and sets spike_dropped.
- All outputs are registered; there are no combinational input-to-output paths.

Optional Feature:
- Macro: SPIKE_CLASSIFIER_MARGIN_EN.
- When defined:
  - Adds output result_margin [CNT_W-1:0] = best count minus second-best count.
  - The second-best register is maintained during SCAN: on a new best, the old best moves to second; otherwise if cnt[idx] > second, second←cnt[idx].
  - On ties, margin=0.
  - result_margin updates with result_valid, resets to 0 and is held between reports.
- When undefined: the port and second-best logic are absent; all other behaviour is identical.

Test Plan:
- Reset then NUM_STEPS=200 steps with no spikes → result_valid exactly once, 41 cycles after the last step pulse; class 0, count 0; spike_dropped=0.
- Inject 5 spikes to AER 7, 9 spikes to AER 22 and 9 spikes to AER 30 over 200 steps → class 22 (tie resolved low), count 9; margin 0 if SPIKE_CLASSIFIER_MARGIN_EN.
- 300 spikes to AER 3 with CNT_W=8 → count saturates at 255, class 3; next sample starts from zeroed counters (3 spikes to AER 39 → class 39, count 3).
- Spikes with AER 40 and 63 during ACCUM → ignored, no counter change; a spike to AER 5 asserted in the same cycle as the final step pulse → counted (class 5, count 1).
- Spike during SCAN → not counted and spike_dropped=1, staying 1 across later samples until rst.
- rst asserted 10 cycles into SCAN → no result_valid; after release, a fresh 200-step sample with 2 spikes to AER 12 → class 12, count 2.
